// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and sizing helpers.
package reset_seq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_HOLD,
    ST_WAIT_ACK,
    ST_GAP,
    ST_DONE,
    ST_FAULT
  } seq_state_e;

  function automatic int unsigned stage_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the reset sequencer (master) and its downstream domains (slave).
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4
);

  localparam int unsigned STAGE_W = stage_width(NUM_STAGES);

  logic                  isoft_rst;
  logic [NUM_STAGES-1:0] iack;
  logic [NUM_STAGES-1:0] orst_n;
  logic [STAGE_W-1:0]    ostage;
  logic                  odone;
  logic                  ofault;

  modport master (
    input  isoft_rst, iack,
    output orst_n, ostage, odone, ofault
  );

  modport slave (
    output isoft_rst, iack,
    input  orst_n, ostage, odone, ofault
  );

endinterface

// File: rtl/reset_sync_2ff.sv
// Asynchronous-assert, synchronous-deassert 2-flop reset synchronizer.
module reset_sync_2ff (
  input  logic iclk,
  input  logic irst_n,
  output logic orst_n
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= 1'b1;
      sync_q <= meta_q;
    end
  end

  assign orst_n = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Ordered release of NUM_STAGES reset domains with per-stage ack and guard gap.
// Optional ack timeout / FAULT state enabled by defining RESET_SEQ_TIMEOUT_EN.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned GAP_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              iclk,
  input  logic              irst_n,
  reset_sequencer_if.master bus
);

  localparam int unsigned STAGE_W = stage_width(NUM_STAGES);
`ifdef RESET_SEQ_TIMEOUT_EN
  localparam int unsigned MAX_CYC = max2(max2(HOLD_CYCLES, GAP_CYCLES), TIMEOUT_CYCLES);
`else
  localparam int unsigned MAX_CYC = max2(HOLD_CYCLES, GAP_CYCLES);
`endif
  localparam int unsigned CNT_W = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUM_STAGES - 1);

  logic sync_rst_n;

  reset_sync_2ff u_sync (
    .iclk   (iclk),
    .irst_n (irst_n),
    .orst_n (sync_rst_n)
  );

  seq_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic [STAGE_W-1:0]    stage_q, stage_d;
  logic                  done_q, done_d;
  logic [STAGE_W-1:0]    next_stage;

  assign next_stage = stage_q + STAGE_W'(1);

`ifdef RESET_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic fault_q, fault_d;
`endif

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      rst_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      stage_q <= stage_d;
      done_q  <= done_d;
`ifdef RESET_SEQ_TIMEOUT_EN
      fault_q <= fault_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    stage_d = stage_q;
    done_d  = done_q;
`ifdef RESET_SEQ_TIMEOUT_EN
    fault_d = fault_q;
`endif
    // Soft reset overrides any same-cycle ack or count terminal.
    if (bus.isoft_rst) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      rst_d   = '0;
      stage_d = '0;
      done_d  = 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
      fault_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (sync_rst_n) begin
            if (cnt_q == HOLD_LAST) begin
              rst_d[0] = 1'b1;
              stage_d  = '0;
              cnt_d    = '0;
              state_d  = ST_WAIT_ACK;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_WAIT_ACK: begin
          if (bus.iack[stage_q]) begin
            cnt_d = '0;
            if (stage_q == STAGE_LAST) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_GAP;
            end
          end
`ifdef RESET_SEQ_TIMEOUT_EN
          else if (cnt_q == TO_LAST) begin
            rst_d   = '0;
            fault_d = 1'b1;
            cnt_d   = '0;
            state_d = ST_FAULT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            stage_d           = next_stage;
            rst_d[next_stage] = 1'b1;
            cnt_d             = '0;
            state_d           = ST_WAIT_ACK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE, ST_FAULT: ;
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          rst_d   = '0;
          stage_d = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  assign bus.orst_n = rst_q;
  assign bus.ostage = stage_q;
  assign bus.odone  = done_q;
`ifdef RESET_SEQ_TIMEOUT_EN
  assign bus.ofault = fault_q;
`else
  assign bus.ofault = 1'b0;
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

endmodule
